// File: rtl/ram_stream_pkg.sv
// rtl/ram_stream_pkg.sv - shared state encodings and constants for ram_stream_reader
package ram_stream_pkg;

    localparam int unsigned SKID_DEPTH     = 2;
    localparam int          DEF_ADDR_WIDTH = 6;
    localparam int          DEF_DATA_WIDTH = 14;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_RUN    = 2'd1;
    localparam state_t ST_FINISH = 2'd2;

    typedef logic [DEF_ADDR_WIDTH:0] len_t;

endpackage

// File: rtl/skid_buffer_2.sv
// rtl/skid_buffer_2.sv - two-entry FIFO that absorbs the RAM read latency
module skid_buffer_2
    import ram_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [1:0]            occupancy
);

    logic [DATA_WIDTH-1:0] entry [SKID_DEPTH];
    logic                  wr_ptr;
    logic                  rd_ptr;

    assign head_data = entry[rd_ptr];

    // The issuer never pushes into a full buffer, so no overflow guard is needed here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry[0]  <= '0;
            entry[1]  <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            if (push) begin
                entry[wr_ptr] <= push_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 2'd1;
                2'b01:   occupancy <= occupancy - 2'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - walks a RAM address range and streams the words out valid/ready
module ram_stream_reader
    import ram_stream_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_write_en,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [ADDR_WIDTH:0]   issue_remaining;
    logic [ADDR_WIDTH:0]   accept_remaining;
    logic                  inflight;
    logic [1:0]            occupancy;
    logic                  issue;
    logic                  pop;
    logic [2:0]            pending;

    assign pop       = out_valid & out_ready;
    assign out_valid = (occupancy != 2'd0);

    // Words buffered or on their way, after this cycle's pop, must leave room for one more.
    assign pending = {1'b0, occupancy} + {2'b0, inflight} - {2'b0, pop};
    assign issue   = (state == ST_RUN) && (issue_remaining != '0)
                     && (pending < 3'(SKID_DEPTH));

    // The RAM registers the address itself, so the issue address is presented combinationally.
    assign mem_addr     = issue ? addr : last_addr;
    assign mem_write_en = 1'b0;
    assign busy         = (state == ST_RUN);
    assign done         = (state == ST_FINISH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            addr             <= '0;
            last_addr        <= '0;
            issue_remaining  <= '0;
            accept_remaining <= '0;
            inflight         <= 1'b0;
        end else begin
            inflight <= issue;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr             <= start_addr;
                        issue_remaining  <= length;
                        accept_remaining <= length;
                        state            <= (length == '0) ? ST_FINISH : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        last_addr       <= addr;
                        addr            <= addr + 1'b1;
                        issue_remaining <= issue_remaining - 1'b1;
                    end
                    if (pop) begin
                        accept_remaining <= accept_remaining - 1'b1;
                        if (accept_remaining == (ADDR_WIDTH+1)'(1)) begin
                            state <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    skid_buffer_2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (mem_data),
        .pop       (pop),
        .head_data (out_data),
        .occupancy (occupancy)
    );

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb/tb_ram_stream_reader.sv - scoreboard bench for ram_stream_reader
module tb_ram_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  start_addr = '0;
    logic [6:0]  length = '0;
    logic        busy, done, mem_write_en, out_valid;
    logic        out_ready = 1'b1;
    logic [5:0]  mem_addr;
    logic [13:0] mem_data = '0;
    logic [13:0] out_data;

    logic [13:0] ram [64];
    logic [13:0] exp_q [$];
    logic [13:0] exp_word;
    logic [5:0]  addr_trace [8];
    logic [5:0]  addr_before;
    logic        pat [7];
    logic        prev_stall = 1'b0;
    logic [13:0] prev_data = '0;

    int checks = 0;
    int failures = 0;
    int done_cyc, busy_cnt, valid_cnt, first_valid, busy_at_done;

    always #5 clk = ~clk;

    ram_stream_reader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .start_addr   (start_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .mem_addr     (mem_addr),
        .mem_write_en (mem_write_en),
        .mem_data     (mem_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    always @(posedge clk) mem_data <= ram[mem_addr];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted word and checks stall stability.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", int'(out_valid), 1);
                    check("stall_data", int'(out_data), int'(prev_data));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_word actual=%0d expected=none", out_data);
                    end else begin
                        exp_word = exp_q.pop_front();
                        check("out_data", int'(out_data), int'(exp_word));
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    task automatic run(input int sa, input int len, input bit rmode, input int abort_at);
        for (int k = 0; k < len; k++) exp_q.push_back(ram[(sa + k) % 64]);
        done_cyc = -1; busy_cnt = 0; valid_cnt = 0; first_valid = -1; busy_at_done = -1;
        start = 1'b1; start_addr = 6'(sa); length = 7'(len); out_ready = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            start      = (c == 2);
            start_addr = 6'd33;
            length     = 7'd5;
            out_ready  = rmode ? pat[(c - 1) % 7] : 1'b1;
            if (c == abort_at) begin
                rst_n = 1'b0;
                return;
            end
            #1;
            if (c < 8) addr_trace[c[2:0]] = mem_addr;
            if (busy) busy_cnt++;
            if (out_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = c;
            end
            if (done) begin
                done_cyc     = c;
                busy_at_done = int'(busy);
                break;
            end
        end
        if (done_cyc < 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=none expected=done sa=%0d len=%0d", sa, len);
        end
    endtask

    initial begin
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 64; i++) ram[i] = 14'(i + 100);
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_write_en", int'(mem_write_en), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run(5, 4, 1'b0, 0);
        check("t1_done_cycle", done_cyc, 7);
        check("t1_busy_cycles", busy_cnt, 6);
        check("t1_busy_at_done", busy_at_done, 0);
        check("t1_first_valid", first_valid, 3);
        check("t1_valid_cycles", valid_cnt, 4);
        check("t1_mem_addr_c1", int'(addr_trace[1]), 5);
        check("t1_drained", exp_q.size(), 0);
        @(negedge clk);

        run(62, 4, 1'b0, 0);
        check("t2_addr_c1", int'(addr_trace[1]), 62);
        check("t2_addr_c2", int'(addr_trace[2]), 63);
        check("t2_addr_c3", int'(addr_trace[3]), 0);
        check("t2_addr_c4", int'(addr_trace[4]), 1);
        check("t2_done_cycle", done_cyc, 7);
        check("t2_drained", exp_q.size(), 0);
        @(negedge clk);

        addr_before = mem_addr;
        run(9, 0, 1'b0, 0);
        check("t3_done_cycle", done_cyc, 1);
        check("t3_valid_cycles", valid_cnt, 0);
        check("t3_mem_addr_hold", int'(addr_trace[1]), int'(addr_before));
        @(negedge clk);

        run(30, 8, 1'b1, 0);
        check("t4_valid_seen", int'(valid_cnt > 0), 1);
        check("t4_drained", exp_q.size(), 0);
        @(negedge clk);

        run(10, 64, 1'b0, 0);
        check("t5_done_cycle", done_cyc, 67);
        check("t5_first_valid", first_valid, 3);
        check("t5_valid_cycles", valid_cnt, 64);
        check("t5_busy_cycles", busy_cnt, 66);
        check("t5_drained", exp_q.size(), 0);
        @(negedge clk);

        run(20, 10, 1'b0, 4);
        #1;
        check("t6_rst_out_valid", int'(out_valid), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_done", int'(done), 0);
        check("t6_rst_mem_addr", int'(mem_addr), 0);
        check("t6_rst_out_data", int'(out_data), 0);
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check("t6_held_done", int'(done), 0);
            check("t6_held_valid", int'(out_valid), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(40, 3, 1'b0, 0);
        check("t6_restart_addr", int'(addr_trace[1]), 40);
        check("t6_restart_done", done_cyc, 6);
        check("t6_restart_first_valid", first_valid, 3);
        check("t6_drained", exp_q.size(), 0);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
